// File: rtl/link_rx_pkg.sv
// Shared constants and elaboration helpers for the DDR link receive path.
package link_rx_pkg;

  localparam int DEF_CHANNEL_WIDTH = 8;
  localparam int DEF_NUM_CHANNELS  = 2;
  localparam int DEF_CORE_WIDTH    = 64;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_TOKEN_BATCH   = 4;

  function automatic int beats_of(input int core_w, input int nch, input int chw);
    return core_w / (nch * chw);
  endfunction

  // Extra MSB is the wrap bit that separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int chw, input int nch, input int core_w,
                                   input int depth, input int batch);
    return (chw > 0) && (nch > 0) && (core_w % (nch * chw) == 0) &&
           (core_w / (nch * chw) >= 2) && (depth >= 2) &&
           ((depth & (depth - 1)) == 0) && (batch > 0) && (depth % batch == 0);
  endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop happens in the same cycle. Head reads as zero when empty.
module link_rx_fifo
  import link_rx_pkg::*;
#(
  parameter int WIDTH = DEF_CORE_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // At full the write slot equals the head slot; the pop consumes the old value first.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/link_ddr_downstream_rx.sv
// DDR link receiver: beat reassembly, receive FIFO, credit token return.
// Optional LINK_RX_STATS_EN adds a saturating count of accepted words.
module link_ddr_downstream_rx
  import link_rx_pkg::*;
#(
  parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int CORE_WIDTH    = DEF_CORE_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int TOKEN_BATCH   = DEF_TOKEN_BATCH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CHANNELS-1:0]             io_valid_i,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] io_data_i,
  output logic                                core_valid_o,
  output logic [CORE_WIDTH-1:0]               core_data_o,
  input  logic                                core_ready_i,
  output logic                                token_o,
  output logic                                overflow_o,
  output logic                                skew_err_o,
  output logic [15:0]                         rx_count_o
);

  localparam int BEATS = beats_of(CORE_WIDTH, NUM_CHANNELS, CHANNEL_WIDTH);
  localparam int SLICE = CORE_WIDTH / NUM_CHANNELS;
  localparam int BW    = $clog2(BEATS);
  localparam int TW    = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;

  generate
    if (!params_ok(CHANNEL_WIDTH, NUM_CHANNELS, CORE_WIDTH, FIFO_DEPTH, TOKEN_BATCH)) begin : g_bad_params
      $error("link_ddr_downstream_rx: inconsistent parameters");
    end
  endgenerate

  logic [BW-1:0]         beat_cnt;
  logic [CORE_WIDTH-1:0] partial;
  logic [CORE_WIDTH-1:0] word_next;
  logic [CORE_WIDTH-1:0] push_word;
  logic                  push_q;
  logic                  all_valid;
  logic                  any_valid;
  logic                  last_beat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [TW-1:0]         pop_cnt;

  assign all_valid = &io_valid_i;
  assign any_valid = |io_valid_i;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));

  // Each channel owns a contiguous SLICE of the word, filled low beat first.
  always_comb begin
    word_next = partial;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      word_next[c*SLICE + int'(beat_cnt)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
        io_data_i[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      partial    <= '0;
      push_word  <= '0;
      push_q     <= 1'b0;
      skew_err_o <= 1'b0;
    end else begin
      push_q <= all_valid && last_beat;
      if (all_valid) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          partial   <= '0;
          push_word <= word_next;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          partial  <= word_next;
        end
      end
      if (any_valid && !all_valid) skew_err_o <= 1'b1;
    end
  end

  link_rx_fifo #(
    .WIDTH (CORE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_word),
    .pop       (pop),
    .head      (core_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign core_valid_o = !fifo_empty;
  assign pop          = core_valid_o && core_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o <= 1'b0;
      pop_cnt    <= '0;
      token_o    <= 1'b0;
    end else begin
      if (push_q && fifo_full && !pop) overflow_o <= 1'b1;
      if (pop) begin
        if (pop_cnt == TW'(TOKEN_BATCH - 1)) begin
          pop_cnt <= '0;
          token_o <= ~token_o;
        end else begin
          pop_cnt <= pop_cnt + 1'b1;
        end
      end
    end
  end

`ifdef LINK_RX_STATS_EN
  logic        push_accepted;
  logic [15:0] rx_count;

  assign push_accepted = push_q && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count <= '0;
    end else if (push_accepted && (rx_count != 16'hFFFF)) begin
      rx_count <= rx_count + 16'd1;
    end
  end

  assign rx_count_o = rx_count;
`else
  assign rx_count_o = '0;
`endif

endmodule
